// File: rtl/ovc_credit_status_pkg.sv
// ovc_credit_status_pkg: shared types, the counter-width helper and the error bit indices for the OVC credit block.
package ovc_credit_status_pkg;
  typedef enum logic [1:0] {FREE, ALLOC, DRAIN} ovc_state_t;
  localparam int ERR_NO_CREDIT  = 0;
  localparam int ERR_CRD_OVF    = 1;
  localparam int ERR_ALLOC_BUSY = 2;
  function automatic int cw_f(input int b);
    return $clog2(b + 1);
  endfunction
endpackage

// File: rtl/ovc_credit_slot.sv
// ovc_credit_slot: one output VC's credit counter and allocation state machine.
// OVC_ATOMIC_REALLOC_EN holds a VC in DRAIN until every downstream credit is back.
module ovc_credit_slot
  import ovc_credit_status_pkg::*;
#(
  parameter int B = 4,
  localparam int CW = cw_f(B)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc,
  input  logic          sent,
  input  logic          tail,
  input  logic          credit,
  output logic [CW-1:0] cnt,
  output ovc_state_t    st,
  output logic          err_nc,
  output logic          err_ovf,
  output logic          err_busy
);
  localparam logic [CW-1:0] BV = CW'(B);
  logic [CW-1:0] r_cnt, w_cnt_next;
  ovc_state_t    r_st, w_st_next, w_post;
  logic          w_tail;
  assign w_tail = sent & tail;
  // Counter saturates at both ends; misuse is reported through the error pulses.
  always_comb begin
    w_cnt_next = (sent & ~credit) ? ((r_cnt == '0) ? '0 : r_cnt - 1'b1) :
                 (credit & ~sent) ? ((r_cnt == BV) ? BV : r_cnt + 1'b1) : r_cnt;
`ifdef OVC_ATOMIC_REALLOC_EN
    w_post = (w_cnt_next == BV) ? FREE : DRAIN;
`else
    w_post = FREE;
`endif
    w_st_next = (r_st == FREE)  ? (alloc ? (w_tail ? w_post : ALLOC) : FREE) :
                (r_st == ALLOC) ? (w_tail ? w_post : ALLOC) :
                ((w_cnt_next == BV) ? FREE : DRAIN);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= BV;
      r_st  <= FREE;
    end else begin
      r_cnt <= w_cnt_next;
      r_st  <= w_st_next;
    end
  end
  assign cnt      = r_cnt;
  assign st       = r_st;
  assign err_nc   = sent & (r_cnt == '0);
  assign err_ovf  = credit & ~sent & (r_cnt == BV);
  assign err_busy = alloc & (r_st != FREE);
endmodule

// File: rtl/ovc_credit_status.sv
// ovc_credit_status: per-output-port OVC credit and allocation bookkeeping feeding the VC/SW allocator.
// Build option OVC_ATOMIC_REALLOC_EN (see ovc_credit_slot) enables atomic reallocation.
module ovc_credit_status
  import ovc_credit_status_pkg::*;
#(
  parameter int V = 4,
  parameter int B = 4,
  localparam int CW = cw_f(B)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [V-1:0]    ovc_allocated,
  input  logic [V-1:0]    flit_sent,
  input  logic            flit_is_tail,
  input  logic [V-1:0]    credit_in,
  output logic [V-1:0]    ovc_avail,
  output logic [V-1:0]    ovc_not_full,
  output logic [V*CW-1:0] credit_count_all,
  output logic [2:0]      err_flags
);
  logic [V-1:0] w_nc, w_ovf, w_busy;
  logic [2:0]   w_err, r_err;
  for (genvar i = 0; i < V; i++) begin : g_slot
    logic [CW-1:0] w_cnt;
    ovc_state_t    w_st;
    ovc_credit_slot #(.B(B)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .alloc   (ovc_allocated[i]),
      .sent    (flit_sent[i]),
      .tail    (flit_is_tail),
      .credit  (credit_in[i]),
      .cnt     (w_cnt),
      .st      (w_st),
      .err_nc  (w_nc[i]),
      .err_ovf (w_ovf[i]),
      .err_busy(w_busy[i])
    );
    assign ovc_avail[i]              = (w_st == FREE);
    assign ovc_not_full[i]           = (w_cnt != '0);
    assign credit_count_all[i*CW +: CW] = w_cnt;
  end
  always_comb begin
    w_err                 = '0;
    w_err[ERR_NO_CREDIT]  = |w_nc;
    w_err[ERR_CRD_OVF]    = |w_ovf;
    w_err[ERR_ALLOC_BUSY] = |w_busy;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_err <= '0;
    else       r_err <= r_err | w_err;
  end
  assign err_flags = r_err;
endmodule

// File: tb/tb_ovc_credit_status.sv
// tb_ovc_credit_status: directed vector table plus hand sequences for reset-time behaviour.
module tb_ovc_credit_status;
  localparam int V = 4, B = 4, CW = 3;
`ifdef OVC_ATOMIC_REALLOC_EN
  localparam bit AT = 1'b1;
`else
  localparam bit AT = 1'b0;
`endif
  logic clk = 0, reset = 1, flit_is_tail = 0;
  logic [V-1:0] ovc_allocated = 0, flit_sent = 0, credit_in = 0;
  logic [V-1:0] ovc_avail, ovc_not_full;
  logic [V*CW-1:0] credit_count_all;
  logic [2:0] err_flags;
  int total = 0, bad = 0;

  ovc_credit_status #(.V(V), .B(B)) dut (
    .clk(clk), .reset(reset), .ovc_allocated(ovc_allocated), .flit_sent(flit_sent),
    .flit_is_tail(flit_is_tail), .credit_in(credit_in), .ovc_avail(ovc_avail),
    .ovc_not_full(ovc_not_full), .credit_count_all(credit_count_all), .err_flags(err_flags)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a, s; logic t; logic [3:0] c;
    logic [3:0] av, nf; logic [11:0] cnt; logic [2:0] err;
  } vec_t;
  vec_t q[$];

  function automatic logic [11:0] pk(input int c3, c2, c1, c0);
    return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  task automatic v(input logic [3:0] a, s, input logic t, input logic [3:0] c,
                   input logic [3:0] av, nf, input logic [11:0] cnt, input logic [2:0] err);
    vec_t e;
    e.a = a; e.s = s; e.t = t; e.c = c; e.av = av; e.nf = nf; e.cnt = cnt; e.err = err;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [15:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] a, s, input logic t, input logic [3:0] c);
    ovc_allocated = a; flit_sent = s; flit_is_tail = t; credit_in = c;
    @(posedge clk);
    @(negedge clk);
    ovc_allocated = 0; flit_sent = 0; flit_is_tail = 0; credit_in = 0;
  endtask

  initial begin
    // grant/send VC1 to empty, same-cycle send+credit on VC2, overflow, single-flit VC0, VC3 errors
    v(4'h0, 4'h0, 0, 4'h0, 4'b1111, 4'b1111, pk(4,4,4,4), 3'b000);
    v(4'h2, 4'h0, 0, 4'h0, 4'b1101, 4'b1111, pk(4,4,4,4), 3'b000);
    v(4'h0, 4'h2, 0, 4'h0, 4'b1101, 4'b1111, pk(4,4,3,4), 3'b000);
    v(4'h0, 4'h2, 0, 4'h0, 4'b1101, 4'b1111, pk(4,4,2,4), 3'b000);
    v(4'h0, 4'h2, 0, 4'h0, 4'b1101, 4'b1111, pk(4,4,1,4), 3'b000);
    v(4'h0, 4'h2, 0, 4'h0, 4'b1101, 4'b1101, pk(4,4,0,4), 3'b000);
    v(4'h0, 4'h0, 0, 4'h2, 4'b1101, 4'b1111, pk(4,4,1,4), 3'b000);
    v(4'h4, 4'h0, 0, 4'h0, 4'b1001, 4'b1111, pk(4,4,1,4), 3'b000);
    v(4'h0, 4'h4, 0, 4'h0, 4'b1001, 4'b1111, pk(4,3,1,4), 3'b000);
    v(4'h0, 4'h4, 0, 4'h0, 4'b1001, 4'b1111, pk(4,2,1,4), 3'b000);
    v(4'h0, 4'h4, 0, 4'h4, 4'b1001, 4'b1111, pk(4,2,1,4), 3'b000);
    v(4'h0, 4'h0, 0, 4'h4, 4'b1001, 4'b1111, pk(4,3,1,4), 3'b000);
    v(4'h0, 4'h0, 0, 4'h4, 4'b1001, 4'b1111, pk(4,4,1,4), 3'b000);
    v(4'h0, 4'h0, 0, 4'h4, 4'b1001, 4'b1111, pk(4,4,1,4), 3'b010);
    v(4'h0, 4'h4, 1, 4'h0, AT ? 4'b1001 : 4'b1101, 4'b1111, pk(4,3,1,4), 3'b010);
    v(4'h0, 4'h0, 0, 4'h4, 4'b1101, 4'b1111, pk(4,4,1,4), 3'b010);
    v(4'h1, 4'h1, 1, 4'h0, AT ? 4'b1100 : 4'b1101, 4'b1111, pk(4,4,1,3), 3'b010);
    v(4'h0, 4'h0, 0, 4'h0, AT ? 4'b1100 : 4'b1101, 4'b1111, pk(4,4,1,3), 3'b010);
    v(4'h0, 4'h0, 0, 4'h1, 4'b1101, 4'b1111, pk(4,4,1,4), 3'b010);
    v(4'h8, 4'h0, 0, 4'h0, 4'b0101, 4'b1111, pk(4,4,1,4), 3'b010);
    v(4'h8, 4'h0, 0, 4'h0, 4'b0101, 4'b1111, pk(4,4,1,4), 3'b110);
    v(4'h0, 4'h8, 0, 4'h0, 4'b0101, 4'b1111, pk(3,4,1,4), 3'b110);
    v(4'h0, 4'h8, 0, 4'h0, 4'b0101, 4'b1111, pk(2,4,1,4), 3'b110);
    v(4'h0, 4'h8, 0, 4'h0, 4'b0101, 4'b1111, pk(1,4,1,4), 3'b110);
    v(4'h0, 4'h8, 0, 4'h0, 4'b0101, 4'b0111, pk(0,4,1,4), 3'b110);
    v(4'h0, 4'h8, 0, 4'h0, 4'b0101, 4'b0111, pk(0,4,1,4), 3'b111);

    repeat (2) @(negedge clk);
    check("rst_avail", 16'(ovc_avail), 16'hF);
    check("rst_not_full", 16'(ovc_not_full), 16'hF);
    check("rst_cnt", 16'(credit_count_all), 16'(pk(4,4,4,4)));
    check("rst_err", 16'(err_flags), 16'h0);
    reset = 0;
    @(negedge clk);

    for (int i = 0; i < q.size(); i++) begin
      step(q[i].a, q[i].s, q[i].t, q[i].c);
      check($sformatf("v%0d_avail", i), 16'(ovc_avail), 16'(q[i].av));
      check($sformatf("v%0d_not_full", i), 16'(ovc_not_full), 16'(q[i].nf));
      check($sformatf("v%0d_cnt", i), 16'(credit_count_all), 16'(q[i].cnt));
      check($sformatf("v%0d_err", i), 16'(err_flags), 16'(q[i].err));
    end

    // VC2 mid-packet with one credit left, then asynchronous reset between clock edges
    step(4'h4, 4'h0, 0, 4'h0);
    repeat (3) step(4'h0, 4'h4, 0, 4'h0);
    check("mid_avail2", 16'(ovc_avail[2]), 16'h0);
    check("mid_cnt2", 16'(credit_count_all[6 +: 3]), 16'h1);
    #2 reset = 1;
    #1;
    check("arst_avail", 16'(ovc_avail), 16'hF);
    check("arst_not_full", 16'(ovc_not_full), 16'hF);
    check("arst_cnt", 16'(credit_count_all), 16'(pk(4,4,4,4)));
    check("arst_err", 16'(err_flags), 16'h0);
    @(negedge clk);
    reset = 0;
    step(4'h2, 4'h0, 0, 4'h0);
    check("post_rst_grant", 16'(ovc_avail), 16'hD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ovc_credit_status.md
# ovc_credit_status

Output-port OVC bookkeeping block: the downstream-facing counterpart of the combined VC/SW allocator. It tracks, per output VC of one router port, the downstream buffer credits and the allocation state. It consumes allocator grants, flit departures and credits returned by the neighbour router. It produces the `ovc_avail` / `ovc_not_full` status vectors from which the allocator's masked OVC requests and `assigned_ovc_not_full` are built. One instance per output port, placed between the allocator outputs and the crossbar/credit link.

## Interface
- `V`, 4, number of VCs per port.
- `B`, 4, downstream buffer depth per VC, in flits; must be ≥ 2.
- `CW`, `$clog2(B+1)`, credit counter width (derived, not overridden).
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `ovc_allocated`  in  V  one-hot/zero pulse: allocator granted this OVC to a header this cycle.
- `flit_sent`  in  V  one-hot/zero: a flit leaves on this OVC this cycle.
- `flit_is_tail`  in  1  qualifies `flit_sent`; departing flit is a tail (or single-flit packet).
- `credit_in`  in  V  per-VC credit return from downstream, any number of bits per cycle.
- `ovc_avail`  out  V  OVC is free for new VC allocation.
- `ovc_not_full`  out  V  credit count of OVC ≠ 0.
- `credit_count_all`  out  V·CW  packed counters; VC i at bits `[i*CW +: CW]`.
- `err_flags`  out  3  sticky: [0] send without credit, [1] credit overflow, [2] allocation of non-free OVC.

## Operation
- Per VC: a credit counter `cnt` and a state `st`. The states are FREE and ALLOC, plus DRAIN when the macro below is set.
- Counter update: `cnt_next = cnt - flit_sent[i] + credit_in[i]`.
  - Send and credit in the same cycle leaves `cnt` unchanged.
- Send when `cnt==0`:
  - set `err_flags[0]`;
  - the counter saturates at 0 (no wrap).
- Credit when `cnt==B` with no simultaneous send:
  - set `err_flags[1]`;
  - the counter saturates at B.
- FREE → ALLOC on `ovc_allocated[i]`.
  - If the same cycle also has `flit_sent[i] & flit_is_tail` (single-flit packet), the VC goes directly to the post-tail state instead.
- ALLOC → post-tail state on `flit_sent[i] & flit_is_tail`. Non-tail sends keep ALLOC.
- `ovc_allocated[i]` while `st≠FREE`:
  - set `err_flags[2]`;
  - the state is unchanged.
- `ovc_avail[i] = (st==FREE)`.
- `ovc_not_full[i] = (cnt≠0)`.
- `err_flags` clears only on reset.

## Timing
- Reset values:
  - `cnt = B` for every VC;
  - `st = FREE`;
  - `ovc_avail` = all ones;
  - `ovc_not_full` = all ones;
  - `credit_count_all` = B in every field;
  - `err_flags` = 0.
- Reset asserted mid-packet returns all VCs to FREE/B immediately (asynchronous), discarding in-flight state.
- All outputs are driven from registers or from pure decode of registers. There is no combinational path from inputs to outputs.
- Latency:
  - a grant in cycle N makes `ovc_avail[i]` drop in N+1;
  - a tail sent in cycle N makes `ovc_avail[i]` rise in N+1 (non-atomic mode);
  - a credit in cycle N is visible in `cnt` and `ovc_not_full` in N+1.
- The allocator must not rely on same-cycle release. The earliest re-grant of a freed VC is N+1.

## Configuration
- Macro `OVC_ATOMIC_REALLOC_EN`.
- Defined:
  - post-tail state is DRAIN;
  - DRAIN → FREE when `cnt_next == B`, i.e. all downstream slots are returned;
  - DRAIN → FREE in the tail cycle itself if `cnt_next==B` then;
  - a VC is never reallocated while the downstream buffer holds a previous packet.
- Undefined:
  - post-tail state is FREE;
  - DRAIN does not exist;
  - reallocation is allowed with credits still outstanding.

## Structure
- Shared package additions:
  - `ovc_state_t` enum (FREE, ALLOC, DRAIN);
  - localparam helper for `CW`;
  - err-bit index constants `ERR_NO_CREDIT`, `ERR_CRD_OVF`, `ERR_ALLOC_BUSY`.
- One natural sub-module, `ovc_credit_slot`: a single-VC counter plus state machine, instantiated V times in a generate loop. Sticky error bits are the OR of the per-slot pulses, registered in the top level.

## Test plan
- Reset with B=4, V=4 → `ovc_avail`=4'b1111, `ovc_not_full`=4'b1111, every `cnt`=4, `err_flags`=0.
- Grant VC1, send 4 body flits with no credits → VC1 `cnt` 4→0. `ovc_not_full[1]`=0 one cycle after the 4th send. `ovc_avail[1]`=0 from the cycle after the grant.
- With `cnt`=2, `flit_sent[2]` and `credit_in[2]` in the same cycle → `cnt` stays 2 and no error. Then credit at `cnt`=4 → `err_flags[1]`=1, `cnt`=4.
- Single-flit packet: grant VC0 plus tail send in the same cycle.
  - Non-atomic: `ovc_avail[0]` stays 1.
  - Atomic: `ovc_avail[0]`=0 until 1 credit returns, then 1 in the following cycle.
- Grant VC3 while it is in ALLOC → `err_flags[2]`=1, state is unchanged. Send on VC3 at `cnt`=0 → `err_flags[0]`=1, `cnt` stays 0.
- Assert `reset` mid-packet with VC2 in ALLOC and `cnt`=1 → immediately `ovc_avail[2]`=1 and `cnt`=4, without waiting for a clock edge.
